interrupt_controller: RTL



---
 rtl/irq_pkg.sv | 19 +
 rtl/irq_priority_encoder.sv | 25 ++
 rtl/interrupt_controller.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants and state encoding for the interrupt controller
package irq_pkg;

    localparam int IRQ_ID_WIDTH = 5;

    // Register word indices, i.e. byte offset >> 2 (addr[4:2])
    localparam logic [2:0] REG_PENDING  = 3'd0;
    localparam logic [2:0] REG_ENABLE   = 3'd1;
    localparam logic [2:0] REG_EDGE     = 3'd2;
    localparam logic [2:0] REG_CLAIM    = 3'd3;
    localparam logic [2:0] REG_COMPLETE = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ASSERT  = 2'b01,
        ST_SERVICE = 2'b10
    } irq_state_e;

endpackage

// File: rtl/irq_priority_encoder.sv
// rtl/irq_priority_encoder.sv - lowest-index-wins encoder over pending & enabled requests
module irq_priority_encoder
    import irq_pkg::*;
#(
    parameter int N = 8,
    parameter int W = IRQ_ID_WIDTH
) (
    input  logic [N-1:0] req_i,
    output logic         valid_o,
    output logic [W-1:0] index_o
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        valid_o = 1'b0;
        index_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                index_o = W'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - pending/enable/edge registers, claim/complete FSM and read mux
module interrupt_controller
    import irq_pkg::*;
#(
    parameter int NUM_SOURCES = 8,
    parameter int ID_WIDTH    = IRQ_ID_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] irq_src,
    input  logic                   wEn,
    input  logic [4:0]             addr,
    input  logic [31:0]            dataIn,
    output logic [31:0]            dataOut,
    output logic                   interrupt,
    output logic [ID_WIDTH-1:0]    interrupt_id
);

    logic [NUM_SOURCES-1:0] s1_q, s2_q;
    logic [NUM_SOURCES-1:0] pending_q, pending_d;
    logic [NUM_SOURCES-1:0] enable_q, enable_d;
    logic [NUM_SOURCES-1:0] edge_q, edge_d;
    irq_state_e             state_q, state_d;
    logic [ID_WIDTH-1:0]    id_q, id_d;
    logic                   irq_q, irq_d;

    logic [2:0]             sel;
    logic                   wr_pending, wr_enable, wr_edge, wr_claim, wr_complete;
    logic                   claim_fire, complete_fire;
    logic [NUM_SOURCES-1:0] set_vec, clr_vec, active;
    logic                   enc_valid;
    logic [ID_WIDTH-1:0]    enc_index;
    logic                   unused_bits;

    assign unused_bits = ^{addr[1:0], dataIn};

    assign sel         = addr[4:2];
    assign wr_pending  = wEn && (sel == REG_PENDING);
    assign wr_enable   = wEn && (sel == REG_ENABLE);
    assign wr_edge     = wEn && (sel == REG_EDGE);
    assign wr_claim    = wEn && (sel == REG_CLAIM);
    assign wr_complete = wEn && (sel == REG_COMPLETE);

    assign claim_fire    = wr_claim && (state_q == ST_ASSERT);
    assign complete_fire = wr_complete && (state_q == ST_SERVICE);

    assign active = pending_q & enable_q;

    irq_priority_encoder #(
        .N(NUM_SOURCES),
        .W(ID_WIDTH)
    ) u_prio (
        .req_i  (active),
        .valid_o(enc_valid),
        .index_o(enc_index)
    );

    // Sets are OR-ed in after clears so a same-cycle set always wins
    always_comb begin
        set_vec = (edge_q & s1_q & ~s2_q) | (~edge_q & s1_q);
        clr_vec = wr_pending ? dataIn[NUM_SOURCES-1:0] : '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (claim_fire && (id_q == ID_WIDTH'(i))) begin
                clr_vec[i] = 1'b1;
            end
        end
        pending_d = (pending_q & ~clr_vec) | set_vec;
        enable_d  = wr_enable ? dataIn[NUM_SOURCES-1:0] : enable_q;
        edge_d    = wr_edge ? dataIn[NUM_SOURCES-1:0] : edge_q;
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (enc_valid) begin
                    id_d    = enc_index;
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (claim_fire) begin
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (complete_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        irq_d = (state_d == ST_ASSERT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            edge_q    <= '0;
            state_q   <= ST_IDLE;
            id_q      <= '0;
            irq_q     <= 1'b0;
        end else begin
            s1_q      <= irq_src;
            s2_q      <= s1_q;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            edge_q    <= edge_d;
            state_q   <= state_d;
            id_q      <= id_d;
            irq_q     <= irq_d;
        end
    end

    function automatic logic [31:0] widen(input logic [NUM_SOURCES-1:0] v);
        logic [31:0] r;
        r = '0;
        r[NUM_SOURCES-1:0] = v;
        return r;
    endfunction

    always_comb begin
        dataOut = '0;
        case (sel)
            REG_PENDING: dataOut = widen(pending_q);
            REG_ENABLE:  dataOut = widen(enable_q);
            REG_EDGE:    dataOut = widen(edge_q);
            REG_CLAIM: begin
                dataOut[31:30]         = state_q;
                dataOut[ID_WIDTH-1:0]  = id_q;
            end
            default:     dataOut = '0;
        endcase
    end

    assign interrupt    = irq_q;
    assign interrupt_id = id_q;

endmodule
